nf10_axis_sim_pkt_gen: RTL

- Synthesizable AXI4-Stream packet source. Transmit-side counterpart of the stream recorder models used in the reference_nic simulation benches.
- Generates a commanded burst of fixed-length packets with a deterministic byte pattern and NetFPGA-style tuser metadata.
- Drives a 256-bit master stream into the DUT (for example an sram_fifo or interface input). Used in bench and on-board self-test.

---
 rtl/nf10_axis_gen_pkg.sv | 37 +++
 rtl/nf10_axis_beat_fmt.sv | 31 +++
 rtl/nf10_axis_sim_pkt_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/nf10_axis_gen_pkg.sv
// Shared types, constants and the byte-pattern helper for the simulation packet generator.
package nf10_axis_gen_pkg;

  localparam int unsigned BYTES_PER_BEAT = 32;
  localparam int unsigned BEAT_CNT_W     = 11;
  localparam int unsigned DEFAULT_LEN    = 64;
  localparam int unsigned DATA_W         = 8 * BYTES_PER_BEAT;
  localparam int unsigned STRB_W         = BYTES_PER_BEAT;
  localparam int unsigned LEN_W          = 16;
  localparam int unsigned PKT_W          = 8;
  localparam int unsigned LANE_W         = 5;

  localparam int unsigned TUSER_LEN_LSB  = 0;
  localparam int unsigned TUSER_SRC_LSB  = 16;
  localparam int unsigned TUSER_DST_LSB  = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } gen_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } beat_t;

  // Byte (32*beat + lane + pkt_idx) mod 256; only beat[2:0] survives the modulo.
  function automatic logic [7:0] pattern_byte(input logic [2:0]        beat_lsb,
                                              input logic [LANE_W-1:0] lane,
                                              input logic [PKT_W-1:0]  pkt_idx);
    return {beat_lsb, lane} + pkt_idx;
  endfunction

endpackage

// File: rtl/nf10_axis_beat_fmt.sv
// Combinational formatter: tdata/tstrb/tlast for one beat of a packet.
module nf10_axis_beat_fmt
  import nf10_axis_gen_pkg::*;
(
  input  logic [BEAT_CNT_W-1:0] beat,
  input  logic [PKT_W-1:0]      pkt_idx,
  input  logic [LEN_W-1:0]      len,
  output logic [DATA_W-1:0]     tdata_c,
  output logic [STRB_W-1:0]     tstrb_c,
  output logic                  tlast_c
);

  logic [BEAT_CNT_W-1:0] last_beat;
  logic [LANE_W-1:0]     tail;

  // len is never 0 here, so (len-1)/32 is the index of the final beat.
  always_comb begin
    last_beat = BEAT_CNT_W'((32'(len) - 32'd1) >> 5);
    tail      = len[LANE_W-1:0];
    tlast_c   = (beat == last_beat);
    tstrb_c   = '1;
    if (tlast_c && (tail != '0)) begin
      tstrb_c = (STRB_W'(1) << tail) - STRB_W'(1);
    end
    tdata_c = '0;
    for (int i = 0; i < BYTES_PER_BEAT; i++) begin
      tdata_c[8*i +: 8] = tstrb_c[i] ? pattern_byte(beat[2:0], LANE_W'(i), pkt_idx) : 8'd0;
    end
  end

endmodule

// File: rtl/nf10_axis_sim_pkt_gen.sv
// AXI4-Stream packet source: bursts of fixed-length patterned packets with NetFPGA tuser.
module nf10_axis_sim_pkt_gen
  import nf10_axis_gen_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0]  C_SRC_PORT           = 8'h01,
  parameter logic [7:0]  C_DST_PORT           = 8'h04,
  parameter int unsigned C_IPG                = 4
) (
  input  logic                                aclk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [15:0]                         pkt_len,
  input  logic [7:0]                          num_pkts,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [7:0]                          counter,
  output logic                                activity_send,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned GAP_W    = 8;
  localparam logic [GAP_W-1:0] GAP_LAST = (C_IPG == 0) ? '0 : GAP_W'(C_IPG - 1);
  localparam bit          NO_GAP   = (C_IPG == 0);

  gen_state_e state_q, state_d;

  logic [LEN_W-1:0]                len_q;
  logic [PKT_W-1:0]                num_q;
  logic [PKT_W-1:0]                pkt_idx_q;
  logic [BEAT_CNT_W-1:0]           beat_q;
  logic [GAP_W-1:0]                gap_q;
  beat_t                           beat_out_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_q;
  logic                            tvalid_q;
  logic [7:0]                      counter_q;
  logic                            activity_q;
  logic                            busy_q;
  logic                            done_q;

  logic                  hs_c;
  logic                  start_burst_c;
  logic                  load_c;
  logic                  next_pkt_c;
  logic                  last_hs_c;
  logic [BEAT_CNT_W-1:0] fmt_beat_c;
  logic [PKT_W-1:0]      fmt_pkt_c;
  logic [LEN_W-1:0]      eff_len_c;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_c;
  beat_t                 fmt_c;

  assign hs_c          = tvalid_q & m_axis_tready;
  assign start_burst_c = (state_q == ST_IDLE) && start && (num_pkts != '0);
  assign eff_len_c     = (pkt_len == '0) ? LEN_W'(DEFAULT_LEN) : pkt_len;

  always_comb begin
    tuser_c = '0;
    tuser_c[TUSER_LEN_LSB +: LEN_W] = eff_len_c;
    tuser_c[TUSER_SRC_LSB +: 8]     = C_SRC_PORT;
    tuser_c[TUSER_DST_LSB +: 8]     = C_DST_PORT;
  end

  nf10_axis_beat_fmt u_beat_fmt (
    .beat    (fmt_beat_c),
    .pkt_idx (fmt_pkt_c),
    .len     (len_q),
    .tdata_c (fmt_c.data),
    .tstrb_c (fmt_c.strb),
    .tlast_c (fmt_c.last)
  );

  always_ff @(posedge aclk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus the beat-load strobes; the output register always holds the beat on the bus.
  always_comb begin
    state_d    = state_q;
    load_c     = 1'b0;
    next_pkt_c = 1'b0;
    last_hs_c  = 1'b0;
    fmt_beat_c = beat_q;
    fmt_pkt_c  = pkt_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (num_pkts == '0) ? ST_DONE : ST_SEND;
      end
      ST_SEND: begin
        if (!tvalid_q) begin
          load_c = 1'b1;
        end else if (hs_c) begin
          if (!beat_out_q.last) begin
            load_c = 1'b1;
          end else begin
            last_hs_c = 1'b1;
            if ((pkt_idx_q + PKT_W'(1)) == num_q) begin
              state_d = ST_DONE;
            end else if (NO_GAP) begin
              load_c     = 1'b1;
              next_pkt_c = 1'b1;
              fmt_beat_c = '0;
              fmt_pkt_c  = pkt_idx_q + PKT_W'(1);
            end else begin
              state_d = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        // First beat is loaded on the final idle cycle so tvalid stays low exactly C_IPG cycles.
        if (gap_q == GAP_LAST) begin
          load_c     = 1'b1;
          next_pkt_c = 1'b1;
          fmt_beat_c = '0;
          fmt_pkt_c  = pkt_idx_q + PKT_W'(1);
          state_d    = ST_SEND;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      len_q      <= '0;
      num_q      <= '0;
      pkt_idx_q  <= '0;
      beat_q     <= '0;
      gap_q      <= '0;
      beat_out_q <= '0;
      tuser_q    <= '0;
      tvalid_q   <= 1'b0;
      counter_q  <= '0;
      activity_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      activity_q <= hs_c;
      busy_q     <= (state_d == ST_SEND) || (state_d == ST_GAP);
      done_q     <= (state_d == ST_DONE);
      gap_q      <= (state_q == ST_GAP) ? gap_q + GAP_W'(1) : '0;

      if (start_burst_c) begin
        len_q     <= eff_len_c;
        num_q     <= num_pkts;
        pkt_idx_q <= '0;
        beat_q    <= '0;
        tuser_q   <= tuser_c;
      end

      if (load_c) begin
        beat_out_q <= fmt_c;
        tvalid_q   <= 1'b1;
        beat_q     <= fmt_beat_c + BEAT_CNT_W'(1);
      end else if (hs_c) begin
        tvalid_q   <= 1'b0;
      end

      if (next_pkt_c) pkt_idx_q <= pkt_idx_q + PKT_W'(1);
      if (last_hs_c)  counter_q <= counter_q + 8'd1;
    end
  end

  assign m_axis_tdata  = beat_out_q.data;
  assign m_axis_tstrb  = beat_out_q.strb;
  assign m_axis_tlast  = beat_out_q.last;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign counter       = counter_q;
  assign activity_send = activity_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
